// File: rtl/alu_req_sched_if.sv
// Request/response, ALU drive and display bus of the two-requester ALU scheduler.
// slave is the scheduler side, master the requester/ALU/display side.
interface alu_req_sched_if;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ovf;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] disp_val;
    logic              busy;
    logic              grant_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_res,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_ovf, alu_a, alu_b, alu_op,
        output disp_val, busy, grant_id
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_res,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_ovf, alu_a, alu_b, alu_op,
        input  disp_val, busy, grant_id
    );
endinterface

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between two requesters,
// with a programmable settle window, signed-overflow capture and display latch.
module alu_req_sched #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_req_sched_if.slave  bus
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_grant_id;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_ovf;
    logic [DATA_W-1:0] r_disp;

    logic w_gnt;
    logic w_ready0;
    logic w_ready1;
    logic w_accept;
    logic w_rsp_take;
    logic w_ovf;

    // Contention goes to the requester not served last; otherwise the lone valid one.
    always_comb begin
        w_gnt = ~bus.req0_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~r_last;
        end
    end

    // Ready is masked during reset so nothing is offered while state is being cleared.
    assign w_ready0   = rst && (r_state == S_IDLE) && bus.req0_valid && !w_gnt;
    assign w_ready1   = rst && (r_state == S_IDLE) && bus.req1_valid &&  w_gnt;
    assign w_accept   = w_ready0 || w_ready1;
    assign w_rsp_take = r_grant_id ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        w_ovf = 1'b0;
        case (r_alu_op)
            3'b000:  w_ovf = (r_alu_a[3] == r_alu_b[3]) && (bus.alu_res[3] != r_alu_a[3]);
            3'b001:  w_ovf = (r_alu_a[3] != r_alu_b[3]) && (bus.alu_res[3] != r_alu_a[3]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_grant_id <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_ovf  <= 1'b0;
            r_disp     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a    <= w_gnt ? bus.req1_a  : bus.req0_a;
                        r_alu_b    <= w_gnt ? bus.req1_b  : bus.req0_b;
                        r_alu_op   <= w_gnt ? bus.req1_op : bus.req0_op;
                        r_grant_id <= w_gnt;
                        r_cnt      <= CNT_W'(HOLD_CYCLES);
                        r_state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_rsp_data <= bus.alu_res;
                    r_disp     <= bus.alu_res;
                    r_rsp_ovf  <= w_ovf;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_last  <= r_grant_id;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp0_valid = (r_state == S_RESP) && !r_grant_id;
    assign bus.rsp1_valid = (r_state == S_RESP) &&  r_grant_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_ovf    = r_rsp_ovf;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.disp_val   = r_disp;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.grant_id   = r_grant_id;
endmodule
